serial_alu: RTL and testbench

- Sliced, multi-cycle ALU that executes the 3-bit Operation code produced by ALUControlUnit.
- Codes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- Processes operands SLICE bits per cycle, LSB first, with a carry chain held in a register between slices.
- Sits in the multi-cycle datapath EX stage and reports completion with a Done pulse.

---
 rtl/serial_alu.sv | 148 ++++++++++++++
 tb/tb_serial_alu.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu.sv
// Sliced multi-cycle ALU for the EX stage of the multi-cycle datapath.
// Operands are processed SLICE bits per cycle, LSB first. For arithmetic codes
// the carry is held in a register between slices. Completion is a one-cycle
// Done pulse, and Result/Zero/Overflow hold their values until the next Done.
module serial_alu #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       Operation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_acc;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;

    logic [SLICE-1:0] w_aSlice;
    logic [SLICE-1:0] w_bRaw;
    logic [SLICE-1:0] w_bSlice;
    logic [SLICE:0]   w_sum;
    logic [SLICE-1:0] w_slice;
    logic [WIDTH-1:0] w_accNext;
    logic             w_cinMsb;
    logic             w_v;
    logic             w_lastSlice;
    logic [WIDTH-1:0] w_finalRes;
    logic             w_finalOvf;

    // The operand registers shift right every slice, so the active slice always sits in the low bits.
    // For SUB/SLT, B is inverted and the initial carry is 1, which turns the adder into a subtractor.
    assign w_aSlice    = r_a[SLICE-1:0];
    assign w_bRaw      = r_b[SLICE-1:0];
    assign w_bSlice    = w_bRaw ^ {SLICE{r_op[2]}};
    assign w_sum       = {1'b0, w_aSlice} + {1'b0, w_bSlice} + {{SLICE{1'b0}}, r_carry};
    assign w_cinMsb    = w_sum[SLICE-1] ^ w_aSlice[SLICE-1] ^ w_bSlice[SLICE-1];
    assign w_v         = w_cinMsb ^ w_sum[SLICE];
    assign w_lastSlice = (r_cnt == LAST);
    assign w_accNext   = (r_acc >> SLICE) | (WIDTH'(w_slice) << (WIDTH - SLICE));

    // Select the per-slice result for the current operation code.
    always_comb begin
        w_slice = '0;
        case (r_op)
            3'b000:                 w_slice = w_aSlice & w_bRaw;
            3'b001:                 w_slice = w_aSlice | w_bRaw;
            3'b010, 3'b110, 3'b111: w_slice = w_sum[SLICE-1:0];
            default:                w_slice = '0;
        endcase
    end

    // Form the architectural result and overflow from the last slice; undefined codes yield zero.
    always_comb begin
        w_finalRes = '0;
        w_finalOvf = 1'b0;
        case (r_op)
            3'b000, 3'b001: w_finalRes = w_accNext;
            3'b010, 3'b110: begin
                w_finalRes = w_accNext;
                w_finalOvf = w_v;
            end
            3'b111:         w_finalRes = WIDTH'(w_accNext[WIDTH-1] ^ w_v);
            default:        w_finalRes = '0;
        endcase
    end

    // Control FSM: capture operands on Start, run N slices, then publish the result with a Done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_op    <= Operation;
                        r_cnt   <= '0;
                        r_carry <= Operation[2];
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_a     <= r_a >> SLICE;
                    r_b     <= r_b >> SLICE;
                    r_carry <= w_sum[SLICE];
                    r_acc   <= w_accNext;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_lastSlice) begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_finalRes;
                        r_zero   <= (w_finalRes == '0);
                        r_ovf    <= w_finalOvf;
                    end
                end
            endcase
        end
    end

    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Result   = r_result;
    assign Zero     = r_zero;
    assign Overflow = r_ovf;

endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu. Issued operations push their expected
// outcome (from an arithmetic reference model) into a queue. A negedge monitor
// pops entries when Done is due and checks Busy/Done/Result/Zero/Overflow every
// cycle. Two extra instances cover the SLICE=1 and SLICE=WIDTH corners.
module tb_serial_alu;

    localparam int W = 32;
    localparam int N = 4;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         Start;
    logic [2:0]   Operation;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result;
    logic         Zero;
    logic         Overflow;

    logic         sStart;
    logic [2:0]   sOp;
    logic [W-1:0] sA;
    logic [W-1:0] sB;
    logic         busy1, done1, zero1, ovf1;
    logic [W-1:0] res1;
    logic         busy32, done32, zero32, ovf32;
    logic [W-1:0] res32;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   monOn = 1'b0;
    exp_t q[$];
    int   lastStart = -100;
    int   freeCycle = 0;
    logic [W-1:0] modelResult = '0;
    logic         modelZero = 1'b0;
    logic         modelOvf = 1'b0;

    serial_alu #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Operation(Operation),
        .A(A), .B(B), .Busy(Busy), .Done(Done), .Result(Result),
        .Zero(Zero), .Overflow(Overflow)
    );

    serial_alu #(.WIDTH(32), .SLICE(1)) dut1 (
        .clk(clk), .reset(reset), .Start(sStart), .Operation(sOp),
        .A(sA), .B(sB), .Busy(busy1), .Done(done1), .Result(res1),
        .Zero(zero1), .Overflow(ovf1)
    );

    serial_alu #(.WIDTH(32), .SLICE(32)) dut32 (
        .clk(clk), .reset(reset), .Start(sStart), .Operation(sOp),
        .A(sA), .B(sB), .Busy(busy32), .Done(done32), .Result(res32),
        .Zero(zero32), .Overflow(ovf32)
    );

    // Free-running clock and cycle counter used for latency bookkeeping.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Architectural behaviour of each operation code, expressed with plain arithmetic.
    function automatic exp_t refModel(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.res = '0;
        e.ovf = 1'b0;
        e.cyc = 0;
        case (op)
            3'b000: e.res = a & b;
            3'b001: e.res = a | b;
            3'b010: begin
                e.res = a + b;
                e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'b110: begin
                e.res = a - b;
                e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'b111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: e.res = '0;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one Start pulse; the model decides from its own timeline whether it is accepted.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        Start     = 1'b1;
        Operation = op;
        A         = a;
        B         = b;
        if (cyc >= freeCycle) begin
            e         = refModel(op, a, b);
            e.cyc     = cyc + N + 1;
            q.push_back(e);
            lastStart = cyc;
            freeCycle = cyc + N + 1;
        end
        @(posedge clk);
        #1;
        Start     = 1'b0;
        Operation = 3'($urandom);
        A         = $urandom;
        B         = $urandom;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        lastStart   = -100;
        freeCycle   = 0;
        modelResult = '0;
        modelZero   = 1'b0;
        modelOvf    = 1'b0;
        reset       = 1'b0;
    endtask

    // Launch one op on both corner instances and check their latencies and results.
    task automatic sweepOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int c0, d1, d32;
        logic [W-1:0] r1c, r32c;
        logic z1c, o1c, z32c, o32c;
        e      = refModel(op, a, b);
        c0     = cyc;
        d1     = -1;
        d32    = -1;
        r1c    = '0; r32c = '0; z1c = 1'b0; o1c = 1'b0; z32c = 1'b0; o32c = 1'b0;
        sStart = 1'b1;
        sOp    = op;
        sA     = a;
        sB     = b;
        @(posedge clk);
        #1;
        sStart = 1'b0;
        sA     = $urandom;
        sB     = $urandom;
        repeat (40) begin
            @(negedge clk);
            checkOutput("sweep busy&done", {31'b0, (busy1 & done1) | (busy32 & done32)}, 32'd0);
            if (done1 && d1 < 0) begin
                d1 = cyc; r1c = res1; z1c = zero1; o1c = ovf1;
            end
            if (done32 && d32 < 0) begin
                d32 = cyc; r32c = res32; z32c = zero32; o32c = ovf32;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("slice1 latency", 32'(d1 - c0), 32'd33);
        checkOutput("slice1 result", r1c, e.res);
        checkOutput("slice1 zero", {31'b0, z1c}, {31'b0, e.zero});
        checkOutput("slice1 ovf", {31'b0, o1c}, {31'b0, e.ovf});
        checkOutput("slice32 latency", 32'(d32 - c0), 32'd2);
        checkOutput("slice32 result", r32c, e.res);
        checkOutput("slice32 zero", {31'b0, z32c}, {31'b0, e.zero});
        checkOutput("slice32 ovf", {31'b0, o32c}, {31'b0, e.ovf});
    endtask

    // Monitor: every cycle compare Done/Busy against the model timeline and outputs against the last expected result.
    always @(negedge clk) begin
        if (monOn) begin
            bit expDone;
            bit expBusy;
            exp_t e;
            expDone = (q.size() > 0) && (q[0].cyc == cyc);
            expBusy = (cyc > lastStart) && (cyc < freeCycle);
            checkOutput("Done", {31'b0, Done}, {31'b0, expDone});
            checkOutput("Busy", {31'b0, Busy}, {31'b0, expBusy});
            if (expDone) begin
                e = q.pop_front();
                modelResult = e.res;
                modelZero   = e.zero;
                modelOvf    = e.ovf;
            end
            checkOutput("Result", Result, modelResult);
            checkOutput("Zero", {31'b0, Zero}, {31'b0, modelZero});
            checkOutput("Overflow", {31'b0, Overflow}, {31'b0, modelOvf});
        end
    end

    initial begin
        reset     = 1'b1;
        Start     = 1'b0;
        Operation = 3'b000;
        A         = '0;
        B         = '0;
        sStart    = 1'b0;
        sOp       = 3'b000;
        sA        = '0;
        sB        = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset Busy", {31'b0, Busy}, 32'd0);
        checkOutput("reset Done", {31'b0, Done}, 32'd0);
        checkOutput("reset Result", Result, 32'd0);
        checkOutput("reset Zero", {31'b0, Zero}, 32'd0);
        checkOutput("reset Overflow", {31'b0, Overflow}, 32'd0);
        reset = 1'b0;
        monOn = 1'b1;
        waitCycles(1);

        $display("[TB] directed operations");
        applyStimulus(3'b010, 32'h7FFF_FFFF, 32'h0000_0001); waitCycles(N);
        applyStimulus(3'b110, 32'h0000_0100, 32'h0000_0001); waitCycles(N);
        applyStimulus(3'b110, 32'd5, 32'd5);                 waitCycles(N);
        applyStimulus(3'b111, 32'h8000_0000, 32'h0000_0001); waitCycles(N);
        applyStimulus(3'b111, 32'h0000_0001, 32'h8000_0000); waitCycles(N);
        applyStimulus(3'b111, 32'd3, 32'd3);                 waitCycles(N);
        applyStimulus(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00); waitCycles(N);
        applyStimulus(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00); waitCycles(N);
        applyStimulus(3'b101, 32'hF0F0_F0F0, 32'hFF00_FF00); waitCycles(N + 1);

        $display("[TB] handshake sequence");
        applyStimulus(3'b010, 32'h1234_0000, 32'h0000_5678); waitCycles(1);
        applyStimulus(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF); waitCycles(2);
        applyStimulus(3'b110, 32'h0000_0010, 32'h0000_0020); waitCycles(1);
        applyReset();
        waitCycles(6);

        $display("[TB] randomized operations");
        for (int i = 0; i < 60; i++) begin
            logic [2:0] opTab [8];
            opTab = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};
            applyStimulus(opTab[$urandom_range(0, 7)], pickOperand(), pickOperand());
            waitCycles($urandom_range(0, 5));
        end
        waitCycles(N + 2);
        checkOutput("scoreboard drained", 32'(q.size()), 32'd0);

        $display("[TB] slice parameter sweep");
        sweepOp(3'b010, 32'hFFFF_FFFF, 32'h0000_0001);
        sweepOp(3'b110, 32'h8000_0000, 32'h0000_0001);
        sweepOp(3'b111, 32'h0000_0001, 32'h8000_0000);
        for (int i = 0; i < 4; i++) begin
            sweepOp(($urandom_range(0, 1) == 0) ? 3'b010 : 3'b110, pickOperand(), pickOperand());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
